// File: rtl/axi4_pkg.sv
// Shared AXI4 codes and the responder state encoding for the data-side SRAM endpoint.
package axi4_pkg;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    localparam logic [1:0] BurstFixed = 2'd0;
    localparam logic [1:0] BurstIncr  = 2'd1;
    localparam logic [1:0] BurstWrap  = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StRLat,
        StRData,
        StWData,
        StWResp
    } rsp_state_e;

endpackage

// File: rtl/axi4_sram_responder_if.sv
// AXI4 read/write channel bundle between the LSU-side master and the SRAM responder.
interface axi4_sram_responder_if #(
    parameter int unsigned ID_W = 4
);
    logic [31:0]     araddr;
    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] arid;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;
    logic            rlast;
    logic [ID_W-1:0] rid;
    logic [31:0]     awaddr;
    logic            awvalid;
    logic            awready;
    logic [ID_W-1:0] awid;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wvalid;
    logic            wready;
    logic            wlast;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [ID_W-1:0] bid;

    modport master (
        output araddr, arvalid, arid, arlen, arsize, arburst, rready,
        output awaddr, awvalid, awid, awlen, awsize, awburst, wdata, wstrb, wvalid, wlast, bready,
        input  arready, rdata, rresp, rvalid, rlast, rid, awready, wready, bresp, bvalid, bid
    );

    modport slave (
        input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
        input  awaddr, awvalid, awid, awlen, awsize, awburst, wdata, wstrb, wvalid, wlast, bready,
        output arready, rdata, rresp, rvalid, rlast, rid, awready, wready, bresp, bvalid, bid
    );

endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Next-beat address and legality check shared by the read and write paths.
// BASE_ADDR is assumed word-aligned.
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic [31:0]                    addr,
    input  logic [2:0]                     size,
    input  logic [1:0]                     burst,
    output logic [31:0]                    next_addr,
    output logic [$clog2(DEPTH_WORDS)-1:0] idx,
    output logic                           ok
);

    logic [29:0] word;
    logic        in_range;

    always_comb begin
        word      = addr[31:2] - BASE_ADDR[31:2];
        in_range  = (addr >= BASE_ADDR) && ({2'b00, word} < DEPTH_WORDS);
        ok        = in_range && (size <= 3'd2) && (burst == BurstFixed || burst == BurstIncr);
        // WRAP and reserved codes step like INCR; they are already flagged above.
        next_addr = (burst == BurstFixed) ? addr : addr + (32'd1 << size);
        idx       = word[$clog2(DEPTH_WORDS)-1:0];
    end

endmodule

// File: rtl/axi4_sram_responder.sv
// Single-outstanding AXI4 responder in front of a word-organised SRAM, with configurable
// read latency and SLVERR on out-of-range or illegal beats.
module axi4_sram_responder
    import axi4_pkg::*;
#(
    parameter int unsigned ID_W        = 4,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned RD_LAT      = 1
) (
    input logic                  clk,
    input logic                  rst,
    axi4_sram_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    rsp_state_e      state;
    logic [31:0]     addr;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic [7:0]      beats;
    logic [3:0]      lat_cnt;
    logic            werr;
    logic            rvalid, rlast, wready, bvalid;
    logic [31:0]     rdata;
    logic [1:0]      rresp, bresp;
    logic [ID_W-1:0] rid, bid;

    logic [31:0]      gen_addr, next_addr, ld_data;
    logic [2:0]       gen_size;
    logic [1:0]       gen_burst;
    logic [7:0]       ld_beats;
    logic [IDX_W-1:0] idx;
    logic             ok, do_load, wr_err;

    axi4_burst_addr_gen #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .BASE_ADDR  (BASE_ADDR)
    ) u_addr_gen (
        .addr     (gen_addr),
        .size     (gen_size),
        .burst    (gen_burst),
        .next_addr(next_addr),
        .idx      (idx),
        .ok       (ok)
    );

    // In IDLE the generator looks at the incoming AR so a 1-cycle latency can load immediately.
    always_comb begin
        if (state == StIdle) begin
            gen_addr  = bus.araddr;
            gen_size  = bus.arsize;
            gen_burst = bus.arburst;
            ld_beats  = bus.arlen;
        end else begin
            gen_addr  = addr;
            gen_size  = size;
            gen_burst = burst;
            ld_beats  = beats;
        end
        ld_data = ok ? mem[idx] : 32'd0;
        wr_err  = !ok || (bus.wlast != (beats == 8'd0));
        do_load = (state == StIdle && bus.arvalid && RD_LAT == 32'd1) ||
                  (state == StRLat && lat_cnt <= 4'd1) ||
                  (state == StRData && bus.rready && !rlast);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= StIdle;
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            bvalid <= 1'b0;
            wready <= 1'b0;
            rdata  <= 32'd0;
            rresp  <= RespOkay;
            rid    <= '0;
            bresp  <= RespOkay;
            bid    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.arvalid) begin
                        size  <= bus.arsize;
                        burst <= bus.arburst;
                        rid   <= bus.arid;
                        if (RD_LAT == 32'd1) begin
                            state <= StRData;
                        end else begin
                            addr    <= bus.araddr;
                            beats   <= bus.arlen;
                            lat_cnt <= 4'(RD_LAT - 1);
                            state   <= StRLat;
                        end
                    end else if (bus.awvalid) begin
                        addr   <= bus.awaddr;
                        size   <= bus.awsize;
                        burst  <= bus.awburst;
                        beats  <= bus.awlen;
                        bid    <= bus.awid;
                        werr   <= 1'b0;
                        wready <= 1'b1;
                        state  <= StWData;
                    end
                end
                StRLat: begin
                    if (lat_cnt <= 4'd1) state <= StRData;
                    else lat_cnt <= lat_cnt - 4'd1;
                end
                StRData: begin
                    if (bus.rready && rlast) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        state  <= StIdle;
                    end
                end
                StWData: begin
                    if (bus.wvalid) begin
                        if (ok) begin
                            for (int i = 0; i < 4; i++) begin
                                if (bus.wstrb[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                            end
                        end
                        addr <= next_addr;
                        werr <= werr | wr_err;
                        if (beats == 8'd0) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bresp  <= (werr || wr_err) ? RespSlverr : RespOkay;
                            state  <= StWResp;
                        end else begin
                            beats <= beats - 8'd1;
                        end
                    end
                end
                StWResp: begin
                    if (bus.bready) begin
                        bvalid <= 1'b0;
                        state  <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase

            // Present the next read beat; later assignments here take priority over the case above.
            if (do_load) begin
                rvalid <= 1'b1;
                rdata  <= ld_data;
                rresp  <= ok ? RespOkay : RespSlverr;
                rlast  <= (ld_beats == 8'd0);
                beats  <= ld_beats - 8'd1;
                addr   <= next_addr;
            end
        end
    end

    assign bus.arready = rst && (state == StIdle);
    assign bus.awready = rst && (state == StIdle) && !bus.arvalid;
    assign bus.rvalid  = rvalid;
    assign bus.rdata   = rdata;
    assign bus.rresp   = rresp;
    assign bus.rlast   = rlast;
    assign bus.rid     = rid;
    assign bus.wready  = wready;
    assign bus.bvalid  = bvalid;
    assign bus.bresp   = bresp;
    assign bus.bid     = bid;

endmodule
